// File: rtl/riscv_crypto_sha256_pkg.sv
// rtl/riscv_crypto_sha256_pkg.sv - SHA-256 round constants, IV, FSM encoding and FU op bits
package riscv_crypto_sha256_pkg;

    localparam int INSTR_W_DEF     = 20;
    localparam int OP_SIG0_BIT_DEF = 13;
    localparam int OP_SIG1_BIT_DEF = 12;
    localparam int OP_SUM0_BIT_DEF = 11;
    localparam int OP_SUM1_BIT_DEF = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SIG0  = 3'd1;
    localparam logic [2:0] ST_SIG1  = 3'd2;
    localparam logic [2:0] ST_SUM0  = 3'd3;
    localparam logic [2:0] ST_SUM1  = 3'd4;
    localparam logic [2:0] ST_FINAL = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [0:63][31:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/riscv_crypto_sha256_kconst.sv
// rtl/riscv_crypto_sha256_kconst.sv - combinational round-constant ROM
module riscv_crypto_sha256_kconst
    import riscv_crypto_sha256_pkg::*;
(
    input  logic [5:0]  i_round,
    output logic [31:0] o_k
);

    assign o_k = K_TABLE[i_round];

endmodule

// File: rtl/riscv_crypto_sha256_seq.sv
// rtl/riscv_crypto_sha256_seq.sv - SHA-256 compression sequencer driving the crypto FU
module riscv_crypto_sha256_seq
    import riscv_crypto_sha256_pkg::*;
#(
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int OP_SIG0_BIT = OP_SIG0_BIT_DEF,
    parameter int OP_SIG1_BIT = OP_SIG1_BIT_DEF,
    parameter int OP_SUM0_BIT = OP_SUM0_BIT_DEF,
    parameter int OP_SUM1_BIT = OP_SUM1_BIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic               blk_init,
    input  logic [511:0]       blk_data,
    output logic               dig_valid,
    input  logic               dig_ready,
    output logic [255:0]       digest,
    output logic [31:0]        fu_rs1,
    output logic [INSTR_W-1:0] fu_instr,
    input  logic [31:0]        fu_rd
);

    logic [2:0]  r_state;
    logic [5:0]  r_round;
    logic [31:0] r_w   [0:15];
    logic [31:0] r_v   [0:7];
    logic [31:0] r_hh  [0:7];
    logic [31:0] r_s0;
    logic [31:0] r_s1;
    logic [31:0] r_sum0;

    logic [31:0] w_k;
    logic [31:0] w_ch;
    logic [31:0] w_maj;
    logic [31:0] w_t1;
    logic [31:0] w_t2;
    logic [31:0] w_wnew;

    riscv_crypto_sha256_kconst u_kconst (
        .i_round (r_round),
        .o_k     (w_k)
    );

    // a..h live in r_v[0..7]; S1 is taken straight off fu_rd during SUM1
    assign w_ch   = (r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]);
    assign w_maj  = (r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]);
    assign w_t1   = r_v[7] + fu_rd + w_ch + w_k + r_w[0];
    assign w_t2   = r_sum0 + w_maj;
    assign w_wnew = r_s1 + r_w[9] + r_s0 + r_w[0];

    assign blk_ready = (r_state == ST_IDLE);
    assign dig_valid = (r_state == ST_DONE);
    assign digest    = {r_hh[0], r_hh[1], r_hh[2], r_hh[3],
                        r_hh[4], r_hh[5], r_hh[6], r_hh[7]};

    always_comb begin
        fu_rs1   = '0;
        fu_instr = '0;
        case (r_state)
            ST_SIG0: begin
                fu_rs1                = r_w[1];
                fu_instr[OP_SIG0_BIT] = 1'b1;
            end
            ST_SIG1: begin
                fu_rs1                = r_w[14];
                fu_instr[OP_SIG1_BIT] = 1'b1;
            end
            ST_SUM0: begin
                fu_rs1                = r_v[0];
                fu_instr[OP_SUM0_BIT] = 1'b1;
            end
            ST_SUM1: begin
                fu_rs1                = r_v[4];
                fu_instr[OP_SUM1_BIT] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_round <= '0;
            r_s0    <= '0;
            r_s1    <= '0;
            r_sum0  <= '0;
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                r_v[i]  <= '0;
                r_hh[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) r_w[i] <= blk_data[511-32*i -: 32];
                        for (int i = 0; i < 8; i++) begin
                            r_v[i] <= blk_init ? IV[i] : r_hh[i];
                            if (blk_init) r_hh[i] <= IV[i];
                        end
                        r_round <= '0;
                        r_state <= ST_SIG0;
                    end
                end
                ST_SIG0: begin
                    r_s0    <= fu_rd;
                    r_state <= ST_SIG1;
                end
                ST_SIG1: begin
                    r_s1    <= fu_rd;
                    r_state <= ST_SUM0;
                end
                ST_SUM0: begin
                    r_sum0  <= fu_rd;
                    r_state <= ST_SUM1;
                end
                ST_SUM1: begin
                    r_v[0] <= w_t1 + w_t2;
                    r_v[1] <= r_v[0];
                    r_v[2] <= r_v[1];
                    r_v[3] <= r_v[2];
                    r_v[4] <= r_v[3] + w_t1;
                    r_v[5] <= r_v[4];
                    r_v[6] <= r_v[5];
                    r_v[7] <= r_v[6];
                    for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                    // schedule expansion stops after round 47; the last 16 words are already in the window
                    r_w[15] <= (r_round < 6'd48) ? w_wnew : '0;
                    r_round <= r_round + 6'd1;
                    if (r_round == 6'd63)
                        r_state <= ST_FINAL;
                    else if (r_round < 6'd47)
                        r_state <= ST_SIG0;
                    else
                        r_state <= ST_SUM0;
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) r_hh[i] <= r_hh[i] + r_v[i];
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (dig_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
